// File: rtl/seq_gen.sv
// seq_gen: loads a parallel pattern and shifts out its low len bits MSB-first,
// optionally repeating whole passes until a stop request is seen.
module seq_gen #(
   parameter int WIDTH = 16,
   parameter int LEN_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data,
   input  logic [LEN_W-1:0] len,
   input  logic             rpt,
   input  logic             stop,
   output logic             out,
   output logic             busy,
   output logic             done
);
   localparam int IW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;
   state_t           state;
   logic [WIDTH-1:0] data_q;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    last;
   logic             rpt_q;
   logic             stop_q;
   logic [LEN_W-1:0] eff;
   logic [IW-1:0]    first;
   always_comb begin
      eff   = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
      first = IW'(eff - 1'b1);
   end
   // a stop sampled on the closing edge of a pass still ends that pass
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         out    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         idx    <= '0;
         last   <= '0;
         data_q <= '0;
         rpt_q  <= 1'b0;
         stop_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               out    <= 1'b0;
               busy   <= 1'b0;
               done   <= 1'b0;
               stop_q <= 1'b0;
               if (start && len != '0) begin
                  state  <= SEND;
                  data_q <= data;
                  idx    <= first;
                  last   <= first;
                  rpt_q  <= rpt;
                  out    <= data[first];
                  busy   <= 1'b1;
               end
            end
            SEND: begin
               if (idx != '0) begin
                  idx    <= idx - 1'b1;
                  out    <= data_q[idx - 1'b1];
                  stop_q <= stop_q | stop;
               end else if (!rpt_q || stop_q || stop) begin
                  state  <= FIN;
                  out    <= 1'b0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  stop_q <= 1'b0;
               end else begin
                  idx <= last;
                  out <= data_q[last];
               end
            end
            FIN: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: randomized and directed checks of seq_gen against a pass-level stream model.
module tb_seq_gen;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] data = '0;
   logic [4:0]  len = '0;
   logic        rpt = 1'b0;
   logic        stop = 1'b0;
   logic        out;
   logic        busy;
   logic        done;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] cap = '0;

   seq_gen #(.WIDTH(16), .LEN_W(5)) dut (
      .clk(clk), .reset(reset), .start(start), .data(data), .len(len),
      .rpt(rpt), .stop(stop), .out(out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected stream: passes of the low L bits MSB-first; a stop seen during
   // stream bit ks ends the pass containing ks. Then one done cycle, then idle.
   task automatic run_seq(input logic [15:0] d, input logic [4:0] l, input bit r,
                          input int ks, input bit lock);
      int L, passes, nb;
      L = (l > 16) ? 16 : int'(l);
      @(negedge clk);
      start = 1'b1; data = d; len = l; rpt = r; stop = 1'b0;
      if (L == 0) begin
         for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            start = 1'b0;
            chk("len0_busy", 32'(busy), 0);
            chk("len0_done", 32'(done), 0);
            chk("len0_out", 32'(out), 0);
         end
         return;
      end
      passes = r ? ks / L + 1 : 1;
      nb = passes * L;
      for (int j = 0; j <= nb + 1; j++) begin
         @(negedge clk);
         chk("busy", 32'(busy), 32'(j < nb));
         chk("out", 32'(out), (j < nb) ? 32'(d[L - 1 - (j % L)]) : 0);
         chk("done", 32'(done), 32'(j == nb));
         if (j < nb) cap = {cap[30:0], out};
         start = lock && (j <= nb);
         data  = 16'($urandom);
         len   = 5'($urandom);
         rpt   = 1'($urandom);
         stop  = (j > nb) ? 1'b0 : (r ? (j == ks) : 1'($urandom));
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   initial begin
      logic [15:0] a, b;
      int          l, L;
      bit          r;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out", 32'(out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      reset = 1'b1;

      run_seq(16'h008B, 5'd8, 1'b0, -1, 1'b0);
      run_seq(16'h1234, 5'd0, 1'b0, -1, 1'b0);
      run_seq(16'h0001, 5'd1, 1'b0, -1, 1'b0);
      run_seq(16'hA5C3, 5'd31, 1'b0, -1, 1'b0);
      run_seq(16'h000B, 5'd4, 1'b1, 9, 1'b0);
      run_seq(16'h000B, 5'd4, 1'b1, 3, 1'b0);
      run_seq(16'h00C5, 5'd8, 1'b0, -1, 1'b1);
      run_seq(16'h0036, 5'd6, 1'b1, 7, 1'b1);
      run_seq(16'h5A5A, 5'd16, 1'b0, -1, 1'b0);

      @(negedge clk);
      start = 1'b1; data = 16'h00F0; len = 5'd8; rpt = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         start = 1'b0;
         chk("pre_rst_out", 32'(out), (j == 0) ? 1 : 1);
      end
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_out", 32'(out), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done), 0);
      reset = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("post_rst_done", 32'(done), 0);
         chk("post_rst_busy", 32'(busy), 0);
      end
      run_seq(16'h0069, 5'd8, 1'b0, -1, 1'b0);

      a = 16'($urandom);
      b = 16'($urandom);
      cap = '0;
      run_seq(a, 5'd14, 1'b0, -1, 1'b0);
      run_seq(b, 5'd14, 1'b0, -1, 1'b0);
      chk("loopback", {4'h0, cap[27:0]}, {4'h0, a[13:0], b[13:0]});

      for (int i = 0; i < 40; i++) begin
         l = $urandom_range(0, 20);
         L = (l > 16) ? 16 : l;
         r = 1'($urandom);
         run_seq(16'($urandom), 5'(l), r, (r && L > 0) ? $urandom_range(0, 3 * L - 1) : -1,
                 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
